// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multi-cycle MIPS core. Walks each instruction
//   through IF/ID/EXE/MEM/WB and drives every datapath enable and mux select.
//   op/fun are held stable by the instruction register for the whole
//   instruction; zero is the ALU zero flag, meaningful in EXE.
//
// Parameters
//   HALT_OP         opcode that stops the core
//   ILLEGAL_AS_NOP  1: unknown op/fun retires as a NOP, 0: it enters HALT
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   op, fun, zero   decoder opcode / function field, ALU zero flag
//   state           IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=111
//   pc_we, pc_src   PC write; 00 PC+4, 01 branch target, 10 jump target
//   ir_we           instruction register write
//   reg_we          register file write
//   reg_dst         00 rt, 01 rd, 10 $31
//   wb_src          00 ALU result, 01 memory data, 10 PC
//   mem_we          data memory write
//   alu_src_a       0 rs, 1 shift amount
//   alu_src_b       0 rt, 1 extended imm16
//   ext_sel         0 zero-extend, 1 sign-extend
//   alu_op          000 ADD 001 SUB 010 AND 011 OR 100 SLT 101 SLL
//   illegal         one-cycle pulse in ID for an unknown op/fun
//   halted          high while in HALT
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter logic [5:0] HALT_OP        = 6'b111111,
    parameter bit         ILLEGAL_AS_NOP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] fun,
    input  logic       zero,
    output logic [2:0] state,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       mem_we,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       ext_sel,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic       halted
);

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EXE  = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_HALT = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    typedef enum logic [3:0] {
        K_RTYPE, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE,
        K_J, K_JAL, K_HALT, K_ILLEGAL
    } kind_e;

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    kind_e      kind_s;
    logic [2:0] rtype_alu_s;
    logic       rtype_sll_s;

    // ALU control for the current instruction, shared by EXE/MEM/WB
    logic [2:0] ex_alu_op_s;
    logic       ex_src_a_s;
    logic       ex_src_b_s;
    logic       ex_ext_s;

    logic       pc_we_s;
    logic [1:0] pc_src_s;
    logic       ir_we_s;
    logic       reg_we_s;
    logic [1:0] reg_dst_s;
    logic [1:0] wb_src_s;
    logic       mem_we_s;
    logic       alu_src_a_s;
    logic       alu_src_b_s;
    logic       ext_sel_s;
    logic [2:0] alu_op_s;
    logic       illegal_s;
    logic       halted_s;

    // Instruction classification from the IR fields; HALT_OP wins over any other match
    always_comb begin
        kind_s      = K_ILLEGAL;
        rtype_alu_s = ALU_ADD;
        rtype_sll_s = 1'b0;
        if (op == HALT_OP) begin
            kind_s = K_HALT;
        end else begin
            case (op)
                OP_RTYPE: begin
                    kind_s = K_RTYPE;
                    case (fun)
                        FN_ADD:  rtype_alu_s = ALU_ADD;
                        FN_SUB:  rtype_alu_s = ALU_SUB;
                        FN_AND:  rtype_alu_s = ALU_AND;
                        FN_OR:   rtype_alu_s = ALU_OR;
                        FN_SLT:  rtype_alu_s = ALU_SLT;
                        FN_SLL: begin
                            rtype_alu_s = ALU_SLL;
                            rtype_sll_s = 1'b1;
                        end
                        default: kind_s = K_ILLEGAL;
                    endcase
                end
                OP_ADDI: kind_s = K_ADDI;
                OP_ORI:  kind_s = K_ORI;
                OP_LW:   kind_s = K_LW;
                OP_SW:   kind_s = K_SW;
                OP_BEQ:  kind_s = K_BEQ;
                OP_BNE:  kind_s = K_BNE;
                OP_J:    kind_s = K_J;
                OP_JAL:  kind_s = K_JAL;
                default: kind_s = K_ILLEGAL;
            endcase
        end
    end

    // ALU operation and operand selects; held unchanged from EXE through WB
    // so the ALU result stays valid until it is written back
    always_comb begin
        ex_alu_op_s = ALU_ADD;
        ex_src_a_s  = 1'b0;
        ex_src_b_s  = 1'b0;
        ex_ext_s    = 1'b0;
        case (kind_s)
            K_RTYPE: begin
                ex_alu_op_s = rtype_alu_s;
                ex_src_a_s  = rtype_sll_s;
            end
            K_ADDI, K_LW, K_SW: begin
                ex_alu_op_s = ALU_ADD;
                ex_src_b_s  = 1'b1;
                ex_ext_s    = 1'b1;
            end
            K_ORI: begin
                ex_alu_op_s = ALU_OR;
                ex_src_b_s  = 1'b1;
            end
            K_BEQ, K_BNE: begin
                ex_alu_op_s = ALU_SUB;
            end
            default: begin
                ex_alu_op_s = ALU_ADD;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing; unused encodings recover to IF
    always_comb begin
        next_state_s = S_IF;
        case (state_r)
            S_IF: next_state_s = S_ID;
            S_ID: begin
                case (kind_s)
                    K_J, K_JAL: next_state_s = S_IF;
                    K_HALT:     next_state_s = S_HALT;
                    K_ILLEGAL:  next_state_s = ILLEGAL_AS_NOP ? S_IF : S_HALT;
                    default:    next_state_s = S_EXE;
                endcase
            end
            S_EXE: begin
                case (kind_s)
                    K_LW, K_SW:             next_state_s = S_MEM;
                    K_RTYPE, K_ADDI, K_ORI: next_state_s = S_WB;
                    default:                next_state_s = S_IF;
                endcase
            end
            S_MEM: begin
                if (kind_s == K_LW) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_WB:    next_state_s = S_IF;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_IF;
        endcase
    end

    // Datapath controls; rst_n gates them so no write fires while reset is low
    always_comb begin
        pc_we_s     = 1'b0;
        pc_src_s    = 2'b00;
        ir_we_s     = 1'b0;
        reg_we_s    = 1'b0;
        reg_dst_s   = 2'b00;
        wb_src_s    = 2'b00;
        mem_we_s    = 1'b0;
        alu_src_a_s = 1'b0;
        alu_src_b_s = 1'b0;
        ext_sel_s   = 1'b0;
        alu_op_s    = ALU_ADD;
        illegal_s   = 1'b0;
        halted_s    = 1'b0;
        if (!rst_n) begin
            pc_we_s = 1'b0;
        end else begin
            case (state_r)
                S_IF: begin
                    ir_we_s = 1'b1;
                    pc_we_s = 1'b1;
                end
                S_ID: begin
                    case (kind_s)
                        K_J: begin
                            pc_we_s  = 1'b1;
                            pc_src_s = 2'b10;
                        end
                        K_JAL: begin
                            pc_we_s   = 1'b1;
                            pc_src_s  = 2'b10;
                            reg_we_s  = 1'b1;
                            reg_dst_s = 2'b10;
                            wb_src_s  = 2'b10;
                        end
                        K_ILLEGAL: illegal_s = 1'b1;
                        default:   illegal_s = 1'b0;
                    endcase
                end
                S_EXE: begin
                    alu_op_s    = ex_alu_op_s;
                    alu_src_a_s = ex_src_a_s;
                    alu_src_b_s = ex_src_b_s;
                    ext_sel_s   = ex_ext_s;
                    if (kind_s == K_BEQ) begin
                        pc_src_s = 2'b01;
                        pc_we_s  = zero;
                    end else if (kind_s == K_BNE) begin
                        pc_src_s = 2'b01;
                        pc_we_s  = ~zero;
                    end else begin
                        pc_we_s  = 1'b0;
                    end
                end
                S_MEM: begin
                    alu_op_s    = ex_alu_op_s;
                    alu_src_a_s = ex_src_a_s;
                    alu_src_b_s = ex_src_b_s;
                    ext_sel_s   = ex_ext_s;
                    mem_we_s    = (kind_s == K_SW);
                end
                S_WB: begin
                    alu_op_s    = ex_alu_op_s;
                    alu_src_a_s = ex_src_a_s;
                    alu_src_b_s = ex_src_b_s;
                    ext_sel_s   = ex_ext_s;
                    reg_we_s    = 1'b1;
                    if (kind_s == K_LW) begin
                        wb_src_s = 2'b01;
                    end else if (kind_s == K_RTYPE) begin
                        reg_dst_s = 2'b01;
                    end else begin
                        reg_dst_s = 2'b00;
                    end
                end
                S_HALT:  halted_s = 1'b1;
                default: halted_s = 1'b0;
            endcase
        end
    end

    assign state     = state_r;
    assign pc_we     = pc_we_s;
    assign pc_src    = pc_src_s;
    assign ir_we     = ir_we_s;
    assign reg_we    = reg_we_s;
    assign reg_dst   = reg_dst_s;
    assign wb_src    = wb_src_s;
    assign mem_we    = mem_we_s;
    assign alu_src_a = alu_src_a_s;
    assign alu_src_b = alu_src_b_s;
    assign ext_sel   = ext_sel_s;
    assign alu_op    = alu_op_s;
    assign illegal   = illegal_s;
    assign halted    = halted_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Runs two controllers (unknown op as NOP, unknown op halts) side by side on
//   the same instruction stream. A directed prologue is followed by random
//   instructions, random zero flags and random mid-cycle resets. Expected
//   outputs come from an instruction-level model: each instruction is a list
//   of stages whose length is its CPI, with the controls of each stage taken
//   from a per-instruction table.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fun;
    logic       zero;

    always #5 clk = ~clk;

    logic [2:0] state_n, state_h;
    logic       pc_we_n, pc_we_h, ir_we_n, ir_we_h, reg_we_n, reg_we_h;
    logic [1:0] pc_src_n, pc_src_h, reg_dst_n, reg_dst_h, wb_src_n, wb_src_h;
    logic       mem_we_n, mem_we_h, asa_n, asa_h, asb_n, asb_h, ext_n, ext_h;
    logic [2:0] alu_op_n, alu_op_h;
    logic       ill_n, ill_h, hlt_n, hlt_h;

    multicycle_ctrl #(.HALT_OP(6'b111111), .ILLEGAL_AS_NOP(1'b1)) dut_nop (
        .clk(clk), .rst_n(rst_n), .op(op), .fun(fun), .zero(zero),
        .state(state_n), .pc_we(pc_we_n), .pc_src(pc_src_n), .ir_we(ir_we_n),
        .reg_we(reg_we_n), .reg_dst(reg_dst_n), .wb_src(wb_src_n), .mem_we(mem_we_n),
        .alu_src_a(asa_n), .alu_src_b(asb_n), .ext_sel(ext_n), .alu_op(alu_op_n),
        .illegal(ill_n), .halted(hlt_n)
    );

    multicycle_ctrl #(.HALT_OP(6'b111111), .ILLEGAL_AS_NOP(1'b0)) dut_hlt (
        .clk(clk), .rst_n(rst_n), .op(op), .fun(fun), .zero(zero),
        .state(state_h), .pc_we(pc_we_h), .pc_src(pc_src_h), .ir_we(ir_we_h),
        .reg_we(reg_we_h), .reg_dst(reg_dst_h), .wb_src(wb_src_h), .mem_we(mem_we_h),
        .alu_src_a(asa_h), .alu_src_b(asb_h), .ext_sel(ext_h), .alu_op(alu_op_h),
        .illegal(ill_h), .halted(hlt_h)
    );

    // Output bundle: {state,pc_we,pc_src,ir_we,reg_we,reg_dst,wb_src,mem_we,a,b,ext,alu_op,illegal,halted}
    logic [20:0] vec_n, vec_h;
    assign vec_n = {state_n, pc_we_n, pc_src_n, ir_we_n, reg_we_n, reg_dst_n, wb_src_n,
                    mem_we_n, asa_n, asb_n, ext_n, alu_op_n, ill_n, hlt_n};
    assign vec_h = {state_h, pc_we_h, pc_src_h, ir_we_h, reg_we_h, reg_dst_h, wb_src_h,
                    mem_we_h, asa_h, asb_h, ext_h, alu_op_h, ill_h, hlt_h};

    int errors = 0;
    int checks = 0;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5;
    localparam int C_J = 6, C_JAL = 7, C_HALT = 8, C_ILL = 9;
    localparam int NT = 15;

    // Instruction table
    logic [5:0] t_op [NT];
    logic [5:0] t_fun[NT];
    int         t_cls[NT];
    logic [2:0] t_alu[NT];
    logic       t_a[NT], t_b[NT], t_e[NT];

    task automatic put(input int i, input logic [5:0] o, input logic [5:0] f, input int c,
                       input logic [2:0] al, input logic a, input logic b, input logic e);
        t_op[i] = o; t_fun[i] = f; t_cls[i] = c; t_alu[i] = al;
        t_a[i] = a; t_b[i] = b; t_e[i] = e;
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        for (int i = 0; i < NT; i++) begin
            if (t_op[i] == o && (t_cls[i] != C_R || t_fun[i] == f)) return i;
        end
        return -1;
    endfunction

    // Cycles per instruction
    function automatic int cpi(input int c);
        case (c)
            C_J, C_JAL, C_ILL, C_HALT: return 2;
            C_BEQ, C_BNE:              return 3;
            C_LW:                      return 5;
            default:                   return 4;
        endcase
    endfunction

    // Stage visited at a given cycle of an instruction: 0 IF 1 ID 2 EXE 3 MEM 4 WB
    function automatic int stage_of(input int c, input int p);
        case (p)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return (c == C_LW || c == C_SW) ? 3 : 4;
            default: return 4;
        endcase
    endfunction

    // Model state: per-controller position in the instruction and halt flag
    int         ph[2];
    bit         hm[2];
    int         cur_cls;
    logic [2:0] cur_alu;
    logic       cur_a, cur_b, cur_e;

    function automatic logic [20:0] expect_vec(input int d, input logic z);
        logic [2:0] st, ao;
        logic [1:0] ps, rd, ws;
        logic pw, iw, rw, mw, a, b, e, il, hd;
        int s;
        st = 3'd0; ao = 3'd0; ps = 2'd0; rd = 2'd0; ws = 2'd0;
        pw = 1'b0; iw = 1'b0; rw = 1'b0; mw = 1'b0; a = 1'b0; b = 1'b0; e = 1'b0;
        il = 1'b0; hd = 1'b0;
        if (hm[d]) begin
            st = 3'b111;
            hd = 1'b1;
        end else begin
            s  = stage_of(cur_cls, ph[d]);
            st = 3'(s);
            if (s == 0) begin
                iw = 1'b1; pw = 1'b1;
            end else if (s == 1) begin
                if (cur_cls == C_J)   begin pw = 1'b1; ps = 2'b10; end
                if (cur_cls == C_JAL) begin pw = 1'b1; ps = 2'b10; rw = 1'b1; rd = 2'b10; ws = 2'b10; end
                if (cur_cls == C_ILL) il = 1'b1;
            end else begin
                ao = cur_alu; a = cur_a; b = cur_b; e = cur_e;
                if (s == 2 && cur_cls == C_BEQ) begin ps = 2'b01; pw = z; end
                if (s == 2 && cur_cls == C_BNE) begin ps = 2'b01; pw = ~z; end
                if (s == 3) mw = (cur_cls == C_SW);
                if (s == 4) begin
                    rw = 1'b1;
                    rd = (cur_cls == C_R) ? 2'b01 : 2'b00;
                    ws = (cur_cls == C_LW) ? 2'b01 : 2'b00;
                end
            end
        end
        return {st, pw, ps, iw, rw, rd, ws, mw, a, b, e, ao, il, hd};
    endfunction

    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (!hm[d]) begin
                if (ph[d] == 1 && (cur_cls == C_HALT || (cur_cls == C_ILL && d == 1))) begin
                    hm[d] = 1'b1;
                    ph[d] = 0;
                end else begin
                    ph[d]++;
                    if (ph[d] >= cpi(cur_cls)) ph[d] = 0;
                end
            end
        end
    endtask

    // Directed prologue: lw, sub, beq z=1, beq z=0, jal, unknown op, halt, sw with reset in MEM
    localparam int ND = 8;
    logic [5:0] d_op [ND] = '{6'b100011, 6'b000000, 6'b000100, 6'b000100,
                              6'b000011, 6'b010101, 6'b111111, 6'b101011};
    logic [5:0] d_fun[ND] = '{6'b000000, 6'b100010, 6'b000000, 6'b000000,
                              6'b000000, 6'b000000, 6'b000000, 6'b000000};
    int         d_z  [ND] = '{-1, -1, 1, 0, -1, -1, -1, -1};
    bit         d_rst[ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int  dptr, zmode, idx, hcnt, r;
        bit  do_rst, rst_in_mem;
        put(0,  6'b000000, 6'b100000, C_R,   3'b000, 1'b0, 1'b0, 1'b0);
        put(1,  6'b000000, 6'b100010, C_R,   3'b001, 1'b0, 1'b0, 1'b0);
        put(2,  6'b000000, 6'b100100, C_R,   3'b010, 1'b0, 1'b0, 1'b0);
        put(3,  6'b000000, 6'b100101, C_R,   3'b011, 1'b0, 1'b0, 1'b0);
        put(4,  6'b000000, 6'b101010, C_R,   3'b100, 1'b0, 1'b0, 1'b0);
        put(5,  6'b000000, 6'b000000, C_R,   3'b101, 1'b1, 1'b0, 1'b0);
        put(6,  6'b001000, 6'b000000, C_I,   3'b000, 1'b0, 1'b1, 1'b1);
        put(7,  6'b001101, 6'b000000, C_I,   3'b011, 1'b0, 1'b1, 1'b0);
        put(8,  6'b100011, 6'b000000, C_LW,  3'b000, 1'b0, 1'b1, 1'b1);
        put(9,  6'b101011, 6'b000000, C_SW,  3'b000, 1'b0, 1'b1, 1'b1);
        put(10, 6'b000100, 6'b000000, C_BEQ, 3'b001, 1'b0, 1'b0, 1'b0);
        put(11, 6'b000101, 6'b000000, C_BNE, 3'b001, 1'b0, 1'b0, 1'b0);
        put(12, 6'b000010, 6'b000000, C_J,   3'b000, 1'b0, 1'b0, 1'b0);
        put(13, 6'b000011, 6'b000000, C_JAL, 3'b000, 1'b0, 1'b0, 1'b0);
        put(14, 6'b111111, 6'b000000, C_HALT,3'b000, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; op = 6'd0; fun = 6'd0; zero = 1'b0;
        dptr = 0; zmode = -1; hcnt = 0; rst_in_mem = 1'b0;
        cur_cls = C_ILL; cur_alu = 3'd0; cur_a = 1'b0; cur_b = 1'b0; cur_e = 1'b0;
        #2;
        check_eq("reset_nop", vec_n, 21'd0);
        check_eq("reset_hlt", vec_h, 21'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ph[0] = 0; ph[1] = 0; hm[0] = 1'b0; hm[1] = 1'b0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            do_rst = 1'b0;
            if (!hm[0] && ph[0] == 0) begin
                if (dptr < ND) begin
                    op = d_op[dptr]; fun = d_fun[dptr];
                    zmode = d_z[dptr]; rst_in_mem = d_rst[dptr];
                    dptr++;
                end else begin
                    zmode = -1;
                    r = int'($urandom_range(0, 99));
                    if (r < 3) begin
                        op = 6'b111111; fun = 6'($urandom_range(0, 63));
                    end else if (r < 12) begin
                        op = 6'($urandom_range(0, 63)); fun = 6'($urandom_range(0, 63));
                    end else begin
                        idx = int'($urandom_range(0, 13));
                        op  = t_op[idx];
                        fun = (t_cls[idx] == C_R) ? t_fun[idx] : 6'($urandom_range(0, 63));
                    end
                end
                idx = classify(op, fun);
                if (idx < 0) begin
                    cur_cls = C_ILL; cur_alu = 3'd0; cur_a = 1'b0; cur_b = 1'b0; cur_e = 1'b0;
                end else begin
                    cur_cls = t_cls[idx]; cur_alu = t_alu[idx];
                    cur_a = t_a[idx]; cur_b = t_b[idx]; cur_e = t_e[idx];
                end
            end
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
            #1;
            check_eq($sformatf("nop cyc%0d op%b", cyc, op), vec_n, expect_vec(0, zero));
            check_eq($sformatf("hlt cyc%0d op%b", cyc, op), vec_h, expect_vec(1, zero));

            if (hm[0]) begin
                hcnt++;
                if (hcnt >= 20) do_rst = 1'b1;
            end else begin
                hcnt = 0;
            end
            if (rst_in_mem && !hm[0] && stage_of(cur_cls, ph[0]) == 3) begin
                do_rst = 1'b1;
                rst_in_mem = 1'b0;
            end
            if (dptr >= ND && $urandom_range(0, 59) == 0) do_rst = 1'b1;

            if (do_rst) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("midrst_nop", vec_n, 21'd0);
                check_eq("midrst_hlt", vec_h, 21'd0);
                @(posedge clk);
                #2 rst_n = 1'b1;
                ph[0] = 0; ph[1] = 0; hm[0] = 1'b0; hm[1] = 1'b0; hcnt = 0;
            end else begin
                advance();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
